// File: rtl/comp_filter_mc_if.sv
// rtl/comp_filter_mc_if.sv - sample handshake and filtered-angle bus of comp_filter_mc
interface comp_filter_mc_if #(
   parameter int CH = 3,
   parameter int W  = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [CH*W-1:0] gyro_data;
   logic [CH*W-1:0] acc_angle;
   logic            resync;
   logic            out_valid;
   logic [CH*W-1:0] angle_out;

   modport master (
      output in_valid, gyro_data, acc_angle, resync,
      input  in_ready, out_valid, angle_out
   );

   modport slave (
      input  in_valid, gyro_data, acc_angle, resync,
      output in_ready, out_valid, angle_out
   );
endinterface

// File: rtl/comp_filter_mc.sv
// rtl/comp_filter_mc.sv - multi-channel complementary filter, channels time-shared on one multiplier
module comp_filter_mc #(
   parameter int CH         = 3,
   parameter int W          = 16,
   parameter int FRAC       = 8,
   parameter int ALPHA_FRAC = 8,
   parameter int ALPHA      = 252,
   parameter int GYRO_SHIFT = 6
) (
   input  logic             clk,
   input  logic             RST,
   comp_filter_mc_if.slave  bus
);
   localparam int IW = W + FRAC;
   localparam int SW = IW + 2;
   localparam int DW = IW + 1;
   localparam int CW = ALPHA_FRAC + 2;
   localparam int PW = DW + CW;
   localparam int KW = (CH > 1) ? $clog2(CH) : 1;

   localparam logic signed [CW-1:0] COEF    = CW'((1 << ALPHA_FRAC) - ALPHA);
   localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(IW-1){1'b0}}};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRED = 3'd1;
   localparam logic [2:0] S_MULT = 3'd2;
   localparam logic [2:0] S_UPD  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]             state_q, state_d;
   logic [KW-1:0]          ch_q, ch_d;
   logic [CH*W-1:0]        gyro_q, acc_q, angle_out_q;
   logic                   resync_q, seeded_q, out_valid_q;
   logic signed [IW-1:0]   angle_q [CH];
   logic signed [IW-1:0]   pred_q;
   logic signed [SW-1:0]   corr_q;

   logic signed [W-1:0]    gyro_k, acc_k;
   logic signed [IW-1:0]   inc, acc_ext, angle_k, new_angle;
   logic signed [SW-1:0]   pred_sum, upd_sum, corr_d;
   logic signed [DW-1:0]   diff;
   logic                   last_ch;

   function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) return SAT_MAX[IW-1:0];
      if (v < SAT_MIN) return SAT_MIN[IW-1:0];
      return v[IW-1:0];
   endfunction

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.angle_out = angle_out_q;

   // Per-channel datapath; ch_q selects which captured words and accumulator are in flight.
   always_comb begin
      gyro_k    = gyro_q[ch_q*W +: W];
      acc_k     = acc_q[ch_q*W +: W];
      angle_k   = angle_q[ch_q];
      inc       = $signed({gyro_k, {FRAC{1'b0}}}) >>> GYRO_SHIFT;
      acc_ext   = $signed({acc_k, {FRAC{1'b0}}});
      pred_sum  = SW'(angle_k) + SW'(inc);
      diff      = DW'(acc_ext) - DW'(pred_q);
      corr_d    = SW'((PW'(diff) * PW'(COEF)) >>> ALPHA_FRAC);
      upd_sum   = SW'(pred_q) + corr_q;
      new_angle = (!seeded_q || resync_q) ? acc_ext : sat(upd_sum);
      last_ch   = (ch_q == KW'(CH - 1));
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) begin
            state_d = S_PRED;
            ch_d    = '0;
         end
         S_PRED: state_d = S_MULT;
         S_MULT: state_d = S_UPD;
         S_UPD: begin
            if (last_ch) begin
               state_d = S_DONE;
            end else begin
               state_d = S_PRED;
               ch_d    = ch_q + KW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         gyro_q      <= '0;
         acc_q       <= '0;
         resync_q    <= 1'b0;
         seeded_q    <= 1'b0;
         out_valid_q <= 1'b0;
         angle_out_q <= '0;
         pred_q      <= '0;
         corr_q      <= '0;
         for (int k = 0; k < CH; k++) angle_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               gyro_q   <= bus.gyro_data;
               acc_q    <= bus.acc_angle;
               resync_q <= bus.resync;
            end
            S_PRED: pred_q <= sat(pred_sum);
            S_MULT: corr_q <= corr_d;
            S_UPD: begin
               angle_q[ch_q] <= new_angle;
               // Publish on the last write so angle_out is valid during the DONE cycle.
               if (last_ch) begin
                  out_valid_q <= 1'b1;
                  for (int k = 0; k < CH; k++)
                     angle_out_q[k*W +: W] <= (k == CH - 1) ? new_angle[IW-1:FRAC]
                                                            : angle_q[k][IW-1:FRAC];
               end
            end
            S_DONE:  seeded_q <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/comp_filter_mc.md
Name: comp_filter_mc

Overview:
- Multi-channel, parametrised complementary filter: fuses gyro rate and accelerometer-derived angle per axis into a filtered angle.
- Carries FRAC extra fractional bits internally so small gyro increments and small correction terms accumulate instead of truncating to zero.
- Channels are processed sequentially through one shared multiplier, behind a valid/ready input handshake.
- Sits downstream of the sensor readers and the accel angle (arctan) stage; feeds the motion-controller angle consumers.

Parameters:
CH, 3, number of channels (axes)
W, 16, width of gyro, accel-angle and output angle words (signed two's complement)
FRAC, 8, extra internal fractional bits of the angle accumulator
ALPHA_FRAC, 8, fractional bits of the filter coefficient
ALPHA, 252, gyro weight = ALPHA/2^ALPHA_FRAC (252/256 = 0.984375); 0 < ALPHA < 2^ALPHA_FRAC
GYRO_SHIFT, 6, per-sample gyro scaling (sensitivity*dt) as a right shift

Ports:
clk  input  1  clock
RST  input  1  reset, synchronous, active-low
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample
gyro_data  input  CH*W  signed gyro rate per channel, channel k at [k*W +: W]
acc_angle  input  CH*W  signed accel angle per channel, same packing
resync  input  1  sampled with an accepted sample; forces reseed from acc_angle
out_valid  output  1  one-cycle pulse: angle_out updated
angle_out  output  CH*W  signed filtered angle per channel, same packing

Behaviour:
- Clock and reset: clk; RST synchronous, active-low.
- Reset values:
  - in_ready=1 (state IDLE), out_valid=0, angle_out=0.
  - All internal accumulators cleared; seeded=0.
  - Reset overrides any state, including mid-sequence; a partially processed sample is discarded.
- Internal angle format: signed, W+FRAC bits. Value = angle_LSB * 2^FRAC.
- Handshake:
  - in_ready = (state==IDLE).
  - Accept on a clock edge with in_valid && in_ready; gyro_data, acc_angle and resync are captured into registers at that edge.
  - Inputs are ignored in all other states.
- FSM: IDLE -> (PRED -> MULT -> UPD) per channel 0..CH-1 -> DONE -> IDLE.
  - PRED:
    - inc = sign-extended (gyro << FRAC) >>> GYRO_SHIFT (arithmetic shift, floor).
    - pred = sat(angle[k] + inc).
  - MULT: prod = (acc<<FRAC - pred) * (2^ALPHA_FRAC - ALPHA), full-width signed product; single shared multiplier.
  - UPD:
    - new = sat(pred + (prod >>> ALPHA_FRAC)).
    - If !seeded or resync_reg: new = acc<<FRAC exactly.
    - Write new to angle[k]; k increments; after the last channel go to DONE.
  - DONE:
    - angle_out[k] = angle[k] >>> FRAC (floor) for all k, updated simultaneously.
    - out_valid=1 for this single cycle; seeded<=1.
- Latency: out_valid is high in the cycle 3*CH+1 edges after the accept edge (10 for CH=3). in_ready returns the following cycle.
- Throughput: one sample per 3*CH+2 cycles max. in_valid held high is accepted as soon as in_ready is high.
- Saturation: sat() clamps to [-2^(W-1)*2^FRAC, (2^(W-1)-1)*2^FRAC + 2^FRAC-1]. Intermediate sums are computed at least 2 bits wider before the clamp; no wrap-around is permitted.
- Channels are independent; no state is shared except the multiplier.
- resync with seeded=0 behaves identically to first-sample seeding.

Test Plan:
1. Seeding: CH=3, defaults. Reset, accept acc=(100,-50,0), gyro=0 -> out_valid exactly 10 cycles after accept, angle_out=(100,-50,0). in_ready low cycles 1..10, high at 11.
2. Fractional accel convergence:
   - Seed acc=0, then acc=1000, gyro=0 -> internal 4000, out 15.
   - Next sample -> internal 7937, out 31. The output must not stay at 0.
3. Gyro integration: seed 0, then gyro=6400, acc=0 -> inc=25600, pred=25600, correction -400, internal 25200, out 98.
4. Saturation: seed acc=32700, then gyro=32767, acc=32767 -> pred clamps to 8388607, internal 8388603, out 32767 (no wrap to negative). Mirror with -32768 -> out -32768.
5. Backpressure/resync:
   - in_valid held high -> samples accepted every 11 cycles exactly.
   - Inputs changed while in_ready=0 are ignored.
   - resync=1 with acc=(7,8,9) -> angle_out=(7,8,9).
6. Reset mid-operation: RST low during MULT of channel 1 -> next cycle in_ready=1, out_valid=0, angle_out=0. Next accepted sample reseeds (output equals acc_angle).
